score_engine: RTL and testbench
===============================

// Module: score_engine
// PURPOSE
//  Game-rule stage directly upstream of the score BCD converter / 7-seg displays.
//  Consumes one-cycle event pulses from the edge pulsers (bumper hit, ball drain, new game)
//  and owns the game FSM, ball count, combo multiplier and saturating 16-bit score fed to BCD.
// PARAMETERS
//  BASE_POINTS   100    points per hit at multiplier 1
//  MAX_MULT      4      combo multiplier ceiling (1..7)
//  COMBO_WINDOW  50_000_000  cycles after a hit in which the next hit extends the combo (1 s)
//  BALLS         3      balls per game (1..7)
//  MAX_SCORE     60000  score saturation value (<= 65535)
// PORTS
//  clk         in   1   system clock (MAX10_CLK1_50)
//  rst_n       in   1   asynchronous active-low reset
//  hit         in   1   one-cycle bumper-hit pulse
//  drain       in   1   one-cycle ball-lost pulse
//  new_game    in   1   one-cycle start/restart pulse
//  score       out  16  current score, binary, to BCD converter
//  mult        out  3   current combo multiplier (1..MAX_MULT, 0 when not playing)
//  balls_left  out  3   remaining balls including the one in play
//  game_over   out  1   high in GAME_OVER state
//  playing     out  1   high in PLAY state
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, score=0, mult=0, balls_left=0,
//   game_over=0, playing=0, combo timer=0. All outputs registered.
//  FSM: IDLE --new_game--> PLAY; PLAY --drain with balls_left==1--> GAME_OVER;
//   GAME_OVER --new_game--> PLAY; PLAY --new_game--> PLAY (full restart).
//  Entering PLAY: score=0, balls_left=BALLS, mult=1, timer=0, next cycle.
//  Hit in PLAY (timer>0): mult=min(mult+1,MAX_MULT); else mult=1.
//   score += BASE_POINTS*new mult, saturating at MAX_SCORE; timer reloads COMBO_WINDOW.
//   score/mult visible on the cycle after the hit pulse (latency 1).
//  Timer counts down 1/cycle in PLAY; on reaching 0 with no hit, mult returns to 1.
//  Drain in PLAY: balls_left-=1, mult=1, timer=0; at balls_left==1 -> GAME_OVER,
//   balls_left=0, mult=0; score frozen.
//  Priority in one cycle: new_game > drain > hit. hit+drain together: hit scored first
//   (using pre-drain mult), then drain applied; both visible next cycle.
//  hit/drain ignored in IDLE and GAME_OVER; score holds last value in GAME_OVER.
//  Arithmetic: product width 16+3 bits internally; compare against MAX_SCORE before
//   writing back, never wraps. Timer width $clog2(COMBO_WINDOW+1).
//  Reset asserted mid-game: immediate return to IDLE with reset values.
// STRUCTURE
//  pinball_defs.vh: localparams for FSM encoding (S_IDLE, S_PLAY, S_GAME_OVER) and
//   default BASE_POINTS/BALLS shared with the top level.
//  Sub-module combo_timer (load, clear, count, expired) holds the reload/down-counter;
//   FSM, ball counter and score accumulator stay in score_engine.
// TESTING (bench: COMBO_WINDOW=8, other defaults)
//  1 Reset, pulse hit -> score=0, playing=0; then new_game -> playing=1, balls_left=3, mult=1.
//  2 Hits at cycles 0,4,8,12,16 -> mult 1,2,3,4,4; score 100,300,600,1000,1400.
//  3 Hit, wait 9 cycles, hit -> mult back to 1, score increases by 100 only.
//  4 Hit+drain same cycle at mult=2 -> score+300 (mult 3), balls_left-1, mult=1 next cycle.
//  5 Three drains -> game_over=1, balls_left=0, further hits leave score unchanged;
//    new_game -> score=0, balls_left=3, game_over=0.
//  6 Preload near MAX_SCORE (600 hits) -> score stops at 60000; rst_n low mid-combo ->
//    all outputs zero asynchronously.

Source files
------------

// File: rtl/score_engine_pkg.sv
// Shared definitions for the pinball score engine: FSM encoding, default
// game constants and the saturating score adder.
package score_engine_pkg;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_PLAY      = 2'd1,
        S_GAME_OVER = 2'd2
    } state_e;

    localparam int DEF_BASE_POINTS  = 100;
    localparam int DEF_MAX_MULT     = 4;
    localparam int DEF_COMBO_WINDOW = 50_000_000;
    localparam int DEF_BALLS        = 3;
    localparam int DEF_MAX_SCORE    = 60000;

    // The sum is formed one bit wider than the product so it can never wrap.
    function automatic logic [15:0] sat_add(input logic [15:0] acc,
                                            input logic [18:0] inc,
                                            input logic [15:0] limit);
        logic [19:0] sum;
        sum = {4'b0000, acc} + {1'b0, inc};
        if (sum >= {4'b0000, limit}) begin
            sat_add = limit;
        end else begin
            sat_add = sum[15:0];
        end
    endfunction

endpackage

// File: rtl/score_engine_if.sv
// Event-in / score-out bundle between the edge pulsers, the score engine
// and the BCD display path.
interface score_engine_if;
    logic        hit;
    logic        drain;
    logic        new_game;
    logic [15:0] score;
    logic [2:0]  mult;
    logic [2:0]  balls_left;
    logic        game_over;
    logic        playing;

    modport master (
        output hit, drain, new_game,
        input  score, mult, balls_left, game_over, playing
    );

    modport slave (
        input  hit, drain, new_game,
        output score, mult, balls_left, game_over, playing
    );
endinterface

// File: rtl/score_engine_combo_timer.sv
// Combo window down-counter: reloads on a hit, counts down while playing and
// flags the cycle on which the window runs out.
module score_engine_combo_timer #(
    parameter int WINDOW = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic clear,
    input  logic count,
    output logic active,
    output logic expired
);
    localparam int TW = $clog2(WINDOW + 1);
    localparam logic [TW-1:0] RELOAD = TW'(WINDOW);
    localparam logic [TW-1:0] ONE    = TW'(1);
    localparam logic [TW-1:0] ZERO   = TW'(0);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    // Clear wins over load so a drain in the same cycle as a hit kills the combo.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = ZERO;
        end else if (load) begin
            cnt_d = RELOAD;
        end else if (count && (cnt_q != ZERO)) begin
            cnt_d = cnt_q - ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign active  = (cnt_q != ZERO);
    assign expired = count && !load && !clear && (cnt_q == ONE);

endmodule

// File: rtl/score_engine.sv
// Game-rule stage: game FSM, ball counter, combo multiplier and saturating
// score accumulator feeding the BCD converter.
module score_engine
    import score_engine_pkg::*;
#(
    parameter int BASE_POINTS  = DEF_BASE_POINTS,
    parameter int MAX_MULT     = DEF_MAX_MULT,
    parameter int COMBO_WINDOW = DEF_COMBO_WINDOW,
    parameter int BALLS        = DEF_BALLS,
    parameter int MAX_SCORE    = DEF_MAX_SCORE
) (
    input  logic          clk,
    input  logic          rst_n,
    score_engine_if.slave bus
);
    localparam logic [15:0] BASE_W  = 16'(BASE_POINTS);
    localparam logic [2:0]  MAX_M   = 3'(MAX_MULT);
    localparam logic [2:0]  BALLS_W = 3'(BALLS);
    localparam logic [15:0] LIMIT_W = 16'(MAX_SCORE);

    state_e      state_q, state_d;
    logic [15:0] score_q, score_d;
    logic [2:0]  mult_q, mult_d;
    logic [2:0]  balls_q, balls_d;
    logic        playing_q, playing_d;
    logic        game_over_q, game_over_d;

    logic        valid_state_s;
    logic        start_s;
    logic        in_play_s;
    logic        last_ball_s;
    logic [2:0]  mult_hit_s;
    logic [18:0] pts_s;
    logic        tmr_load_s;
    logic        tmr_clear_s;
    logic        tmr_active_s;
    logic        tmr_expired_s;

    assign valid_state_s = (state_q == S_IDLE) || (state_q == S_PLAY) ||
                           (state_q == S_GAME_OVER);
    assign start_s       = bus.new_game && valid_state_s;
    assign in_play_s     = (state_q == S_PLAY);
    assign last_ball_s   = (balls_q <= 3'd1);
    assign pts_s         = 19'(BASE_W) * 19'(mult_hit_s);

    score_engine_combo_timer #(
        .WINDOW (COMBO_WINDOW)
    ) u_combo_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (tmr_load_s),
        .clear   (tmr_clear_s),
        .count   (in_play_s),
        .active  (tmr_active_s),
        .expired (tmr_expired_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: new_game outranks drain in every state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.new_game) state_d = S_PLAY;
                else              state_d = S_IDLE;
            end
            S_PLAY: begin
                if (bus.new_game)                      state_d = S_PLAY;
                else if (bus.drain && last_ball_s)     state_d = S_GAME_OVER;
                else                                   state_d = S_PLAY;
            end
            S_GAME_OVER: begin
                if (bus.new_game) state_d = S_PLAY;
                else              state_d = S_GAME_OVER;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Registered status flags decoded from the upcoming state.
    always_comb begin
        playing_d   = (state_d == S_PLAY);
        game_over_d = (state_d == S_GAME_OVER);
    end

    // Multiplier a hit would score with this cycle.
    always_comb begin
        mult_hit_s = 3'd1;
        if (tmr_active_s) begin
            if (mult_q >= MAX_M) mult_hit_s = MAX_M;
            else                 mult_hit_s = mult_q + 3'd1;
        end else begin
            mult_hit_s = 3'd1;
        end
    end

    // Score, multiplier and ball datapath; a hit is scored before a same-cycle drain.
    always_comb begin
        score_d     = score_q;
        mult_d      = mult_q;
        balls_d     = balls_q;
        tmr_load_s  = 1'b0;
        tmr_clear_s = 1'b0;
        if (start_s) begin
            score_d     = 16'd0;
            mult_d      = 3'd1;
            balls_d     = BALLS_W;
            tmr_clear_s = 1'b1;
        end else if (in_play_s) begin
            if (bus.hit) begin
                score_d    = sat_add(score_q, pts_s, LIMIT_W);
                mult_d     = mult_hit_s;
                tmr_load_s = 1'b1;
            end else if (tmr_expired_s) begin
                mult_d = 3'd1;
            end else begin
                mult_d = mult_q;
            end
            if (bus.drain) begin
                tmr_clear_s = 1'b1;
                if (last_ball_s) begin
                    balls_d = 3'd0;
                    mult_d  = 3'd0;
                end else begin
                    balls_d = balls_q - 3'd1;
                    mult_d  = 3'd1;
                end
            end else begin
                balls_d = balls_q;
            end
        end else if (!valid_state_s) begin
            score_d     = 16'd0;
            mult_d      = 3'd0;
            balls_d     = 3'd0;
            tmr_clear_s = 1'b1;
        end else begin
            score_d = score_q;
        end
    end

    // Output and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score_q     <= 16'd0;
            mult_q      <= 3'd0;
            balls_q     <= 3'd0;
            playing_q   <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            score_q     <= score_d;
            mult_q      <= mult_d;
            balls_q     <= balls_d;
            playing_q   <= playing_d;
            game_over_q <= game_over_d;
        end
    end

    assign bus.score      = score_q;
    assign bus.mult       = mult_q;
    assign bus.balls_left = balls_q;
    assign bus.game_over  = game_over_q;
    assign bus.playing    = playing_q;

endmodule

// File: tb/tb_score_engine.sv
// Self-checking bench for score_engine with a short combo window: a vector
// table plus hand-written saturation and async-reset sequences.
module tb_score_engine;

    typedef struct packed {
        logic [15:0] score;
        logic [2:0]  mult;
        logic [2:0]  balls;
        logic        go;
        logic        play;
    } out_t;

    typedef struct packed {
        logic h;
        logic d;
        logic n;
        out_t e;
    } vec_t;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;
    out_t sb[$];
    vec_t vecs[$];

    score_engine_if ifc();

    score_engine #(
        .COMBO_WINDOW (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic out_t mk(input int s, input int m, input int b,
                                input bit g, input bit p);
        out_t o;
        o.score = 16'(s);
        o.mult  = 3'(m);
        o.balls = 3'(b);
        o.go    = g;
        o.play  = p;
        return o;
    endfunction

    function automatic void add(input bit h, input bit d, input bit n,
                                input int s, input int m, input int b,
                                input bit g, input bit p);
        vec_t v;
        v.h = h;
        v.d = d;
        v.n = n;
        v.e = mk(s, m, b, g, p);
        vecs.push_back(v);
    endfunction

    task automatic check(input string name);
        out_t got;
        out_t exp_o;
        got = {ifc.score, ifc.mult, ifc.balls_left, ifc.game_over, ifc.playing};
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s: scoreboard empty, got score=%0d", name, got.score);
        end else begin
            exp_o = sb.pop_front();
            tests++;
            if (got !== exp_o) begin
                fails++;
                $display("FAIL %s: got score=%0d mult=%0d balls=%0d go=%0b play=%0b, want score=%0d mult=%0d balls=%0d go=%0b play=%0b",
                         name, got.score, got.mult, got.balls, got.go, got.play,
                         exp_o.score, exp_o.mult, exp_o.balls, exp_o.go, exp_o.play);
            end
        end
    endtask

    task automatic cycle(input bit h, input bit d, input bit n, input out_t e,
                         input string name);
        @(negedge clk);
        ifc.hit      = h;
        ifc.drain    = d;
        ifc.new_game = n;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check(name);
    endtask

    initial begin
        int s_m;
        int s_score;
        tests        = 0;
        fails        = 0;
        ifc.hit      = 1'b0;
        ifc.drain    = 1'b0;
        ifc.new_game = 1'b0;
        rst_n        = 1'b1;

        // Reset state and events ignored in IDLE
        add(1, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 1, 3, 0, 1);
        // Combo build-up with hits every 4 cycles
        add(1, 0, 0, 100, 1, 3, 0, 1);
        for (int k = 0; k < 3; k++) add(0, 0, 0, 100, 1, 3, 0, 1);
        add(1, 0, 0, 300, 2, 3, 0, 1);
        for (int k = 0; k < 3; k++) add(0, 0, 0, 300, 2, 3, 0, 1);
        add(1, 0, 0, 600, 3, 3, 0, 1);
        for (int k = 0; k < 3; k++) add(0, 0, 0, 600, 3, 3, 0, 1);
        add(1, 0, 0, 1000, 4, 3, 0, 1);
        for (int k = 0; k < 3; k++) add(0, 0, 0, 1000, 4, 3, 0, 1);
        add(1, 0, 0, 1400, 4, 3, 0, 1);
        // Window runs out after 8 countdown cycles
        for (int k = 0; k < 7; k++) add(0, 0, 0, 1400, 4, 3, 0, 1);
        add(0, 0, 0, 1400, 1, 3, 0, 1);
        add(0, 0, 0, 1400, 1, 3, 0, 1);
        add(1, 0, 0, 1500, 1, 3, 0, 1);
        // Hit+drain at mult 2
        add(1, 0, 0, 1700, 2, 3, 0, 1);
        add(1, 1, 0, 2000, 1, 2, 0, 1);
        add(1, 0, 0, 2100, 1, 2, 0, 1);
        // Remaining drains end the game; events then ignored
        add(0, 1, 0, 2100, 1, 1, 0, 1);
        add(0, 1, 0, 2100, 0, 0, 1, 0);
        add(1, 0, 0, 2100, 0, 0, 1, 0);
        add(0, 1, 0, 2100, 0, 0, 1, 0);
        add(0, 0, 1, 0, 1, 3, 0, 1);
        // new_game outranks hit and drain
        add(1, 0, 0, 100, 1, 3, 0, 1);
        add(1, 1, 1, 0, 1, 3, 0, 1);
        add(1, 0, 0, 100, 1, 3, 0, 1);

        #2 rst_n = 1'b0;
        sb.push_back(mk(0, 0, 0, 1'b0, 1'b0));
        #1 check("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            cycle(vecs[i].h, vecs[i].d, vecs[i].n, vecs[i].e, $sformatf("vec%0d", i));
        end

        // Saturation: hit every cycle from a fresh game
        cycle(1'b0, 1'b0, 1'b1, mk(0, 1, 3, 1'b0, 1'b1), "sat_start");
        s_m     = 0;
        s_score = 0;
        for (int k = 0; k < 600; k++) begin
            s_m     = (k == 0) ? 1 : ((s_m < 4) ? s_m + 1 : 4);
            s_score = s_score + 100 * s_m;
            if (s_score > 60000) s_score = 60000;
            cycle(1'b1, 1'b0, 1'b0, mk(s_score, s_m, 3, 1'b0, 1'b1),
                  $sformatf("sat_hit%0d", k));
        end
        cycle(1'b1, 1'b0, 1'b0, mk(60000, 4, 3, 1'b0, 1'b1), "sat_hold");

        // Async reset mid-combo, away from any clock edge
        ifc.hit = 1'b0;
        #2 rst_n = 1'b0;
        sb.push_back(mk(0, 0, 0, 1'b0, 1'b0));
        #1 check("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 1'b0, 1'b0, mk(0, 0, 0, 1'b0, 1'b0), "post_reset_hit");
        cycle(1'b0, 1'b0, 1'b1, mk(0, 1, 3, 1'b0, 1'b1), "post_reset_start");

        @(negedge clk);
        ifc.hit      = 1'b0;
        ifc.drain    = 1'b0;
        ifc.new_game = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
